// File: rtl/morse_key_decoder.sv
// Morse key decoder: times key presses in 1 ms ticks, classifies each press
// as a dot or a dash, and emits a completed character once the key has been
// released for the letter-gap timeout.
module morse_key_decoder #(
  parameter int DASH_MS = 300,
  parameter int GAP_MS  = 1000,
  parameter int MAX_SYM = 5,
  parameter int CNT_W   = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       OnemsTimeOut,
  input  logic       key,
  output logic       sym_valid,
  output logic [2:0] sym_len,
  output logic [4:0] sym_bits,
  output logic       sym_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, PRESS, GAP, EMIT} stateT;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DASH_LIM = CNT_W'(DASH_MS);
  localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_MS);
  localparam logic [2:0]       MAX_LEN  = 3'(MAX_SYM);

  stateT            state;
  logic             keyQ;
  logic [CNT_W-1:0] dur;
  logic [CNT_W-1:0] gap;
  logic [2:0]       len;
  logic [4:0]       bits;
  logic             err;

  logic             rise;
  logic             fall;
  logic             elem;
  logic [CNT_W-1:0] durNext;
  logic [CNT_W-1:0] gapNext;

  assign rise    = key & ~keyQ;
  assign fall    = ~key & keyQ;
  assign elem    = (dur >= DASH_LIM);
  assign durNext = (dur == CNT_MAX) ? dur : dur + 1'b1;
  assign gapNext = (gap == CNT_MAX) ? gap : gap + 1'b1;

  // Single FSM: edge detection, press/gap timing, element accumulation and
  // registered character output all advance together on each clock.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state     <= IDLE;
      keyQ      <= 1'b0;
      dur       <= '0;
      gap       <= '0;
      len       <= '0;
      bits      <= '0;
      err       <= 1'b0;
      sym_valid <= 1'b0;
      sym_len   <= '0;
      sym_bits  <= '0;
      sym_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      keyQ      <= key;
      sym_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESS;
            dur   <= '0;
            busy  <= 1'b1;
          end
        end
        PRESS: begin
          if (fall) begin
            if (len < MAX_LEN) begin
              bits <= {bits[3:0], elem};
              len  <= len + 3'd1;
            end else begin
              err <= 1'b1;
            end
            gap   <= '0;
            state <= GAP;
          end else if (OnemsTimeOut) begin
            dur <= durNext;
          end
        end
        GAP: begin
          if (rise) begin
            state <= PRESS;
            dur   <= '0;
          end else if (OnemsTimeOut) begin
            gap <= gapNext;
            if (gapNext == GAP_LIM) begin
              state     <= EMIT;
              busy      <= 1'b0;
              sym_valid <= 1'b1;
              sym_len   <= len;
              sym_bits  <= bits;
              sym_err   <= err;
            end
          end
        end
        EMIT: begin
          len  <= '0;
          bits <= '0;
          err  <= 1'b0;
          dur  <= '0;
          gap  <= '0;
          if (rise) begin
            state <= PRESS;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_key_decoder.sv
// Testbench for morse_key_decoder: drives key press/release segments measured
// in whole ticks and checks the emitted characters against a queue-based
// model of the keyed elements.
module tb_morse_key_decoder;

  localparam int DASH = 3;
  localparam int GAPT = 5;
  localparam int MAXS = 5;
  localparam int CW   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       tick;
  logic       key;
  logic       symValid;
  logic [2:0] symLen;
  logic [4:0] symBits;
  logic       symErr;
  logic       busy;

  int compared   = 0;
  int mismatched = 0;

  bit elems[$];
  int curPress;
  int expLen;
  int expBits;
  int expErr;

  morse_key_decoder #(
    .DASH_MS(DASH),
    .GAP_MS (GAPT),
    .MAX_SYM(MAXS),
    .CNT_W  (CW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .OnemsTimeOut(tick),
    .key         (key),
    .sym_valid   (symValid),
    .sym_len     (symLen),
    .sym_bits    (symBits),
    .sym_err     (symErr),
    .busy        (busy)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic driveCycle(input bit k, input bit t);
    key  = k;
    tick = t;
    @(posedge clk);
    #1;
  endtask

  // Expected character from the keyed elements: first element is the most
  // significant of the used bits; extra elements only raise the error flag.
  task automatic computeExpected();
    expLen  = (elems.size() > MAXS) ? MAXS : elems.size();
    expBits = 0;
    for (int i = 0; i < expLen; i++) expBits = expBits * 2 + int'(elems[i]);
    expErr  = (elems.size() > MAXS) ? 1 : 0;
  endtask

  task automatic checkPulse();
    checkOutput("symLen", symLen, expLen);
    checkOutput("symBits", symBits, expBits);
    checkOutput("symErr", symErr, expErr);
  endtask

  // Hold key at a level for a number of ticks; ticks fall mid-way between
  // key changes so press and gap lengths are unambiguous.
  task automatic applyStimulus(input bit level, input int ticks);
    int cycles;
    int pulses;
    cycles = (ticks == 0) ? 2 : 4 * ticks;
    pulses = 0;
    if (level) begin
      curPress = ticks;
    end else begin
      elems.push_back(curPress >= DASH);
      computeExpected();
    end
    for (int c = 0; c < cycles; c++) begin
      driveCycle(level, (ticks > 0) && (c % 4 == 2));
      if (symValid) begin
        pulses++;
        checkPulse();
      end
    end
    if (level) begin
      checkOutput("pulsesInPress", pulses, 0);
      checkOutput("busyPress", busy, 1);
    end else begin
      checkOutput("pulsesInGap", pulses, (ticks >= GAPT) ? 1 : 0);
      checkOutput("busyGap", busy, (ticks >= GAPT) ? 0 : 1);
      if (ticks >= GAPT) begin
        checkOutput("symLenHold", symLen, expLen);
        elems.delete();
      end
    end
  endtask

  task automatic keyChar(input int p0, input int g0, input int p1, input int g1);
    applyStimulus(1'b1, p0);
    applyStimulus(1'b0, g0);
    if (p1 >= 0) begin
      applyStimulus(1'b1, p1);
      applyStimulus(1'b0, g1);
    end
  endtask

  // Directed scenarios followed by random characters
  initial begin
    int n;
    int pt;
    int pulses;
    rst    = 1'b1;
    enable = 1'b1;
    key    = 1'b0;
    tick   = 1'b0;
    curPress = 0;
    repeat (3) driveCycle(1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("rstValid", symValid, 0);
    checkOutput("rstLen", symLen, 0);
    checkOutput("rstBits", symBits, 0);
    checkOutput("rstErr", symErr, 0);
    checkOutput("rstBusy", busy, 0);

    $display("[TB] letter A");
    keyChar(1, 2, 4, 5);

    $display("[TB] reset mid-press");
    applyStimulus(1'b1, 2);
    rst = 1'b1;
    driveCycle(1'b0, 1'b0);
    rst = 1'b0;
    elems.delete();
    checkOutput("midRstValid", symValid, 0);
    checkOutput("midRstLen", symLen, 0);
    checkOutput("midRstBits", symBits, 0);
    checkOutput("midRstErr", symErr, 0);
    checkOutput("midRstBusy", busy, 0);
    keyChar(1, 5, -1, 0);

    $display("[TB] dash threshold and zero-tick press");
    keyChar(2, 5, -1, 0);
    keyChar(3, 5, -1, 0);
    keyChar(0, 5, -1, 0);

    $display("[TB] saturated press");
    keyChar(10, 5, -1, 0);

    $display("[TB] overflow");
    for (int i = 0; i < 6; i++) keyChar(1, (i == 5) ? 5 : 1, -1, 0);

    $display("[TB] gap race");
    applyStimulus(1'b1, 3);
    elems.push_back(curPress >= DASH);
    pulses = 0;
    for (int c = 0; c < 16; c++) begin
      driveCycle(1'b0, c % 4 == 2);
      if (symValid) pulses++;
    end
    driveCycle(1'b0, 1'b0);
    driveCycle(1'b0, 1'b0);
    driveCycle(1'b1, 1'b1);
    if (symValid) pulses++;
    driveCycle(1'b1, 1'b0);
    if (symValid) pulses++;
    checkOutput("racePulses", pulses, 0);
    checkOutput("raceBusy", busy, 1);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 5);

    $display("[TB] enable low mid-gap");
    keyChar(1, 2, -1, 0);
    enable = 1'b0;
    driveCycle(1'b0, 1'b0);
    enable = 1'b1;
    elems.delete();
    checkOutput("enValid", symValid, 0);
    checkOutput("enBusy", busy, 0);
    pulses = 0;
    for (int c = 0; c < 24; c++) begin
      driveCycle(1'b0, c % 4 == 2);
      if (symValid) pulses++;
    end
    checkOutput("enNoEmit", pulses, 0);
    keyChar(3, 5, -1, 0);

    $display("[TB] random characters");
    for (int ch = 0; ch < 25; ch++) begin
      n = $urandom_range(1, 7);
      for (int i = 0; i < n; i++) begin
        pt = ($urandom_range(0, 7) == 0) ? 9 : $urandom_range(0, 5);
        applyStimulus(1'b1, pt);
        applyStimulus(1'b0, (i == n - 1) ? $urandom_range(5, 6) : $urandom_range(1, 4));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/morse_key_decoder.md
Name: morse_key_decoder

Overview:
- Receive side of the Morse game: measures the duration of player key presses in 1 ms ticks and classifies each press as a dot or a dash.
- Accumulates the elements of one character and emits it as a single-cycle symbol once the key has been released for a letter-gap timeout.
- Consumes the 1 ms timeout strobe produced by the game's millisecond timer chain.
- Its output is compared against the ROM-stored target character.

Parameters:
- DASH_MS, 300, press length in ms at or above which an element is a dash; below it is a dot.
- GAP_MS, 1000, release length in ms that ends a character.
- MAX_SYM, 5, maximum elements per character; must be ≤ 5.
- CNT_W, 12, width of the press and gap counters; must satisfy 2^CNT_W-1 ≥ max(DASH_MS, GAP_MS).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  decoder active; low forces a synchronous clear (same effect as rst).
- OnemsTimeOut  input  1  one-cycle strobe every 1 ms.
- key  input  1  debounced, clk-synchronous Morse key; 1 = pressed.
- sym_valid  output  1  one-cycle pulse when a character is complete.
- sym_len  output  3  number of elements in the character, 0..MAX_SYM.
- sym_bits  output  5  element code; 1 = dash, 0 = dot. First element is at bit sym_len-1, last at bit 0; unused upper bits are 0.
- sym_err  output  1  more than MAX_SYM elements were keyed; valid with sym_valid.
- busy  output  1  high in PRESS or GAP.

Behaviour:
- Reset, or enable low: state = IDLE; key_q, dur, gap, len, bits, err all cleared. sym_valid = 0, sym_len = 0, sym_bits = 0, sym_err = 0, busy = 0.
- Edge detect:
  - key_q is a 1-cycle registered copy of key.
  - rise = key & ~key_q.
  - fall = ~key & key_q.
- IDLE: on rise, go to PRESS with dur = 0. Ticks are ignored.
- PRESS:
  - Each OnemsTimeOut increments dur, saturating at 2^CNT_W-1.
  - On fall, elem = (dur ≥ DASH_MS), using dur before any tick in the same cycle; that tick is dropped.
  - If len < MAX_SYM: bits <= {bits[3:0], elem}, len <= len+1.
  - Else: err <= 1; bits and len are unchanged.
  - Then go to GAP with gap = 0.
- GAP:
  - Each OnemsTimeOut increments gap, saturating.
  - On rise, go to PRESS with dur = 0; gap is discarded.
  - When gap reaches GAP_MS (the tick making gap == GAP_MS) with no rise in that cycle, go to EMIT.
  - If rise and the timeout occur in the same cycle, rise wins.
- EMIT (1 cycle):
  - sym_valid = 1; sym_len/sym_bits/sym_err carry len/bits/err.
  - Next cycle: sym_valid = 0, accumulators cleared, state = IDLE.
  - The sym_* outputs hold their last values until the next EMIT.
  - A rise during the EMIT cycle is not lost: the FSM goes directly to PRESS with dur = 0.
- Boundary cases:
  - A zero-tick press (dur = 0) is a dot.
  - A key held indefinitely saturates dur and classifies as a dash on release.
  - A press exactly DASH_MS ticks long is a dash; DASH_MS-1 ticks is a dot.
  - Latency from the gap-completing tick to sym_valid is 1 cycle.
- Outputs are registered.

Test Plan (bench overrides DASH_MS=3, GAP_MS=5; tick every 4 clk):
- Reset mid-PRESS (key held 2 ticks, rst pulsed) -> all outputs 0, busy = 0; a following 1-tick press plus 5-tick release gives sym_len=1, sym_bits=00000.
- "A" (press 1 tick, release 2 ticks, press 4 ticks, release 5 ticks) -> single sym_valid pulse, sym_len=2, sym_bits=00001, sym_err=0.
- Threshold: press of exactly 2 ticks then 3 ticks, each followed by a 5-tick gap -> sym_bits=0 then 1, sym_len=1 both.
- Overflow: six 1-tick presses separated by 1-tick gaps, then 5-tick gap -> sym_len=5, sym_bits=00000, sym_err=1.
- Gap race: after a dash, rise asserted on the same cycle as the 5th gap tick -> no sym_valid; the next press is appended (sym_len=2 after the final gap).
- enable low mid-GAP for 1 cycle -> no sym_valid; busy=0; the next character decodes from len=0.
